// File: rtl/pipeline_ram_if.sv
// rtl/pipeline_ram_if.sv - request/update bus for the pipelined histogram RAM
//
// Signals:
//   ram_en     increment request
//   addr_r     bin address of the request
//   upd_valid  write-back occurring this cycle
//   upd_addr   bin address being written back
//   upd_count  post-increment count being written back
// Modports: master drives requests and observes updates; slave is the RAM.
interface pipeline_ram_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic              ram_en;
    logic [ADDR_W-1:0] addr_r;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_addr;
    logic [DATA_W-1:0] upd_count;

    modport master (
        output ram_en,
        output addr_r,
        input  upd_valid,
        input  upd_addr,
        input  upd_count
    );

    modport slave (
        input  ram_en,
        input  addr_r,
        output upd_valid,
        output upd_addr,
        output upd_count
    );
endinterface

// File: rtl/pipeline_ram.sv
// rtl/pipeline_ram.sv - pipelined read-modify-write histogram RAM, one increment per cycle
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset (clears all bins and the pipeline)
//   bus  pipeline_ram_if.slave: ram_en/addr_r request in, upd_* write-back out
//
// Pipeline: S1 registers the request and the bin read; S2 registers the
// saturated increment, which is the upd_* output and is written to the bin
// on the following edge. Two bypass paths keep back-to-back and gap-of-one
// requests to the same bin coherent with one-at-a-time behaviour.
module pipeline_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ram_if.slave  bus
);
    logic [DATA_W-1:0] mem [DEPTH];

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_data;

    logic              s2_valid;
    logic [ADDR_W-1:0] s2_addr;
    logic [DATA_W-1:0] s2_count;

    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] next_count;

    // The bin being written back this cycle is not yet in mem when S1 reads
    // it (gap of one request), so take the write-back value instead.
    always_comb begin
        rd_data = mem[bus.addr_r];
        if (s2_valid && (s2_addr == bus.addr_r)) begin
            rd_data = s2_count;
        end
    end

    // Back-to-back requests: S1's read predates the S2 result, so forward it.
    always_comb begin
        operand = s1_data;
        if (s2_valid && (s2_addr == s1_addr)) begin
            operand = s2_count;
        end
    end

    // Saturate at all-ones rather than wrapping to zero.
    always_comb begin
        next_count = operand + DATA_W'(1);
        if (operand == {DATA_W{1'b1}}) begin
            next_count = operand;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_count <= '0;
        end else begin
            s1_valid <= bus.ram_en;
            if (bus.ram_en) begin
                s1_addr <= bus.addr_r;
                s1_data <= rd_data;
            end

            s2_valid <= s1_valid;
            // Address/count hold their last values on idle cycles.
            if (s1_valid) begin
                s2_addr  <= s1_addr;
                s2_count <= next_count;
            end

            if (s2_valid) begin
                mem[s2_addr] <= s2_count;
            end
        end
    end

    assign bus.upd_valid = s2_valid;
    assign bus.upd_addr  = s2_addr;
    assign bus.upd_count = s2_count;
endmodule

// File: tb/tb_pipeline_ram.sv
// tb/tb_pipeline_ram.sv - directed self-checking bench for pipeline_ram
module tb_pipeline_ram;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_ram_if #(.ADDR_W(5), .DATA_W(16)) bus  ();
    pipeline_ram_if #(.ADDR_W(5), .DATA_W(4))  bus4 ();

    pipeline_ram #(.ADDR_W(5), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipeline_ram #(.ADDR_W(5), .DATA_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // Leaves the bench 1 time unit after a rising edge, with rst=1 for the
    // cycle now starting.
    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.ram_en  = 1'b0;
        bus.addr_r  = '0;
        bus4.ram_en = 1'b0;
        bus4.addr_r = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_single();
        int en [14] = '{1,0,0,0,1,0,0,0,1,0,1,0,0,0};
        int ad [14] = '{1,9,9,9,1,9,9,9,5,9,5,9,9,9};
        int ev [14] = '{0,0,1,0,0,0,1,0,0,0,1,0,1,0};
        int ea [14] = '{0,0,1,1,1,1,1,1,1,1,5,5,5,5};
        int ec [14] = '{0,0,1,1,1,1,2,2,2,2,1,1,2,2};
        apply_reset();
        for (int c = 0; c < 14; c++) begin
            bus.ram_en = en[c][0];
            bus.addr_r = 5'(ad[c]);
            @(negedge clk);
            n_checks++;
            if (bus.upd_valid !== ev[c][0] || bus.upd_addr !== 5'(ea[c]) || bus.upd_count !== 16'(ec[c])) begin
                n_fail++;
                $display("FAIL single c%0d: got v=%0b a=%0d n=%0d, want v=%0d a=%0d n=%0d",
                         c, bus.upd_valid, bus.upd_addr, bus.upd_count, ev[c], ea[c], ec[c]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        // Outputs currently hold addr 5 / count 2 from the previous test.
        rst = 1'b0;
        bus.ram_en = 1'b1;
        bus.addr_r = 5'd5;
        @(posedge clk);
        #1;
        bus.addr_r = 5'd1;
        @(negedge clk);
        n_checks++;
        if (bus.upd_valid !== 1'b0 || bus.upd_addr !== 5'd0 || bus.upd_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%0b a=%0d n=%0d, want 0 0 0",
                     bus.upd_valid, bus.upd_addr, bus.upd_count);
        end
        n_checks++;
        if (bus4.upd_valid !== 1'b0 || bus4.upd_addr !== 5'd0 || bus4.upd_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state_w4: got v=%0b a=%0d n=%0d, want 0 0 0",
                     bus4.upd_valid, bus4.upd_addr, bus4.upd_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.addr_r = 5'd5;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (c == 2) begin
                if (bus.upd_valid !== 1'b1 || bus.upd_addr !== 5'd5 || bus.upd_count !== 16'd1) begin
                    n_fail++;
                    $display("FAIL reset_first_req: got v=%0b a=%0d n=%0d, want 1 5 1",
                             bus.upd_valid, bus.upd_addr, bus.upd_count);
                end
            end else if (bus.upd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: got v=%0b, want 0", c, bus.upd_valid);
            end
            @(posedge clk);
            #1;
            bus.ram_en = 1'b0;
        end
    endtask

    task automatic test_consecutive();
        int en [6] = '{1,1,1,0,0,0};
        int ev [6] = '{0,0,1,1,1,0};
        int ea [6] = '{0,0,5,5,5,5};
        int ec [6] = '{0,0,1,2,3,3};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            bus.ram_en = en[c][0];
            bus.addr_r = 5'd5;
            @(negedge clk);
            n_checks++;
            if (bus.upd_valid !== ev[c][0] || bus.upd_addr !== 5'(ea[c]) || bus.upd_count !== 16'(ec[c])) begin
                n_fail++;
                $display("FAIL consecutive c%0d: got v=%0b a=%0d n=%0d, want v=%0d a=%0d n=%0d",
                         c, bus.upd_valid, bus.upd_addr, bus.upd_count, ev[c], ea[c], ec[c]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_interleave();
        int en [7] = '{1,1,1,1,0,0,0};
        int ad [7] = '{3,4,3,4,3,3,3};
        int ev [7] = '{0,0,1,1,1,1,0};
        int ea [7] = '{0,0,3,4,3,4,4};
        int ec [7] = '{0,0,1,1,2,2,2};
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            bus.ram_en = en[c][0];
            bus.addr_r = 5'(ad[c]);
            @(negedge clk);
            n_checks++;
            if (bus.upd_valid !== ev[c][0] || bus.upd_addr !== 5'(ea[c]) || bus.upd_count !== 16'(ec[c])) begin
                n_fail++;
                $display("FAIL interleave c%0d: got v=%0b a=%0d n=%0d, want v=%0d a=%0d n=%0d",
                         c, bus.upd_valid, bus.upd_addr, bus.upd_count, ev[c], ea[c], ec[c]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_gap_mix();
        // Requests to bin 2 at distances 1, 2 and 3.
        int en [10] = '{1,1,0,1,0,0,1,0,0,0};
        int ev [10] = '{0,0,1,1,0,1,0,0,1,0};
        int ea [10] = '{0,0,2,2,2,2,2,2,2,2};
        int ec [10] = '{0,0,1,2,2,3,3,3,4,4};
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            bus.ram_en = en[c][0];
            bus.addr_r = 5'd2;
            @(negedge clk);
            n_checks++;
            if (bus.upd_valid !== ev[c][0] || bus.upd_addr !== 5'(ea[c]) || bus.upd_count !== 16'(ec[c])) begin
                n_fail++;
                $display("FAIL gap_mix c%0d: got v=%0b a=%0d n=%0d, want v=%0d a=%0d n=%0d",
                         c, bus.upd_valid, bus.upd_addr, bus.upd_count, ev[c], ea[c], ec[c]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_inflight();
        int rs [9] = '{1,0,1,1,1,1,1,1,1};
        int en [9] = '{1,1,0,0,0,1,0,0,0};
        int ad [9] = '{6,6,5,5,5,6,5,5,5};
        int ev [9] = '{0,0,0,0,0,0,0,1,0};
        int ea [9] = '{0,0,0,0,0,0,0,6,6};
        int ec [9] = '{0,0,0,0,0,0,0,1,1};
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            rst        = rs[c][0];
            bus.ram_en = en[c][0];
            bus.addr_r = 5'(ad[c]);
            @(negedge clk);
            n_checks++;
            if (bus.upd_valid !== ev[c][0] || bus.upd_addr !== 5'(ea[c]) || bus.upd_count !== 16'(ec[c])) begin
                n_fail++;
                $display("FAIL reset_inflight c%0d: got v=%0b a=%0d n=%0d, want v=%0d a=%0d n=%0d",
                         c, bus.upd_valid, bus.upd_addr, bus.upd_count, ev[c], ea[c], ec[c]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_saturation();
        int exp_v;
        int exp_c;
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            bus4.ram_en = (c < 17);
            bus4.addr_r = 5'd0;
            exp_v = (c >= 2 && c <= 18) ? 1 : 0;
            exp_c = (c < 2) ? 0 : ((c - 1 > 15) ? 15 : c - 1);
            @(negedge clk);
            n_checks++;
            if (bus4.upd_valid !== exp_v[0] || bus4.upd_addr !== 5'd0 || bus4.upd_count !== 4'(exp_c)) begin
                n_fail++;
                $display("FAIL saturation c%0d: got v=%0b a=%0d n=%0d, want v=%0d a=0 n=%0d",
                         c, bus4.upd_valid, bus4.upd_addr, bus4.upd_count, exp_v, exp_c);
            end
            @(posedge clk);
            #1;
        end
        bus4.ram_en = 1'b0;
    endtask

    initial begin
        bus.ram_en  = 1'b0;
        bus.addr_r  = '0;
        bus4.ram_en = 1'b0;
        bus4.addr_r = '0;
        test_single();
        test_reset();
        test_consecutive();
        test_interleave();
        test_gap_mix();
        test_reset_inflight();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_ram.md
PIPELINE_RAM -- requirements
Module: pipeline_ram

Interface
REQ-001 Parameter ADDR_W, default 5, bin address width.
REQ-002 Parameter DATA_W, default 16, bin counter width.
REQ-003 Parameter DEPTH, default 2**ADDR_W, number of bins.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low: asserted when 0, sampled only on rising clk.
REQ-006 ram_en  input  1  increment request; when 1, the bin at addr_r is incremented by one.
REQ-007 addr_r  input  ADDR_W  bin address of the request; ignored when ram_en=0.
REQ-008 upd_valid  output  1  a bin write-back occurs this cycle.
REQ-009 upd_addr  output  ADDR_W  address being written back.
REQ-010 upd_count  output  DATA_W  new count being written back (post-increment).

Function
REQ-011 Block SHALL be a histogram RAM: DEPTH counters, a read-modify-write increment per accepted request.
REQ-012 Throughput: one request accepted every cycle, no stall, no backpressure; requests with ram_en=0 SHALL have no effect.
REQ-013 Stage S1 (edge ending request cycle T): capture valid/address; synchronous read of mem[addr_r] into a stage register.
REQ-014 Stage S2 (edge ending T+1): compute count = operand + 1; register valid, address, count; upd_* outputs are these registers.
REQ-015 Write-back: while upd_valid=1, mem[upd_addr] SHALL be written with upd_count on the edge ending that cycle (edge ending T+2).
REQ-016 Latency: request in cycle T -> upd_valid=1 with its result throughout cycle T+2; memory reflects it from cycle T+3.
REQ-017 Hazard distance 1: if S2 holds a valid entry with the same address as S1, the operand SHALL be the S2 count, not the S1 read data.
REQ-018 Hazard distance 2: if the S1 read address equals upd_addr while upd_valid=1 in the same cycle, the captured read data SHALL be upd_count (write-first bypass).
REQ-019 Every combination of same-address requests (consecutive, gap of 1, gap >=2) SHALL yield counts identical to sequential one-at-a-time increments.
REQ-020 Arithmetic: counts are unsigned DATA_W; increment SHALL saturate at 2**DATA_W-1 (no wrap to 0).
REQ-021 Different addresses in flight SHALL not interact.
REQ-022 When no write-back, upd_valid=0; upd_addr/upd_count SHALL hold their last values.

Reset
REQ-023 While rst=0 at a rising edge: all DEPTH bins SHALL be cleared to 0; S1/S2 valid cleared; upd_valid=0, upd_addr=0, upd_count=0.
REQ-024 Requests presented in a cycle where rst=0 SHALL be discarded; in-flight requests at reset SHALL be dropped and never written back.
REQ-025 First request accepted is the one in the first cycle with rst=1.

Verification
REQ-026 After reset, ram_en=1 addr_r=1 in cycle T only -> cycle T+2: upd_valid=1, upd_addr=1, upd_count=1; all other cycles upd_valid=0.
REQ-027 Then addr_r=1 again 4 cycles later -> upd_count=2; addr_r=5 at cycles T and T+2 -> upd_count 1 then 2 (distance-2 bypass).
REQ-028 addr_r=5 on three consecutive cycles from reset -> upd_count 1,2,3 on three consecutive cycles (distance-1 forward).
REQ-029 Interleaved addr 3,4,3,4 consecutive -> counts 1,1,2,2 with matching upd_addr.
REQ-030 DATA_W=4, 17 consecutive requests to addr 0 -> upd_count 1..15 then 15,15 (saturation).
REQ-031 Request in cycle T, rst=0 in cycle T+1 -> no upd_valid at T+2; subsequent single request to same addr yields upd_count=1; ram_en=0 with addr_r=5 -> no update.
